// File: rtl/meta_queue_pkg.sv
// rtl/meta_queue_pkg.sv - shared types and helpers for the metadata queue
//
// Purpose: per-cycle operation encoding used by the queue's occupancy logic.
// Ports:   none (package).
package meta_queue_pkg;

  // One bit per side of the queue: {push, pop}.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } op_e;

  function automatic op_e decode_op(input logic push, input logic pop);
    return op_e'({push, pop});
  endfunction

endpackage

// File: rtl/meta_queue_if.sv
// rtl/meta_queue_if.sv - valid/ready metadata stream interface
//
// Purpose: one metadata stream (valid, ready, data).
// Modports:
//   m - producer side: drives valid/data, receives ready
//   s - consumer side: receives valid/data, drives ready
interface metaIntf #(
  parameter int DATA_BITS = 64
);

  logic                 valid;
  logic                 ready;
  logic [DATA_BITS-1:0] data;

  modport m (output valid, output data, input ready);
  modport s (input valid, input data, output ready);

endinterface

// File: rtl/meta_queue.sv
// rtl/meta_queue.sv - registered-output FIFO for metadata words
//
// Purpose: DEPTH-entry first-in first-out queue between a metadata producer
//          and consumer. Both handshake outputs come from registered state.
// Ports:
//   aclk            in   single clock, rising edge
//   aresetn         in   asynchronous active-low reset
//   s_meta          s    upstream producer (valid/data in, ready out)
//   m_meta          m    downstream consumer (valid/data out, ready in)
//   count           out  current occupancy, 0..DEPTH
//   stat_pushes     out  accepted pushes, wraps at 2^32 (META_QUEUE_STATS_EN)
//   stat_max_count  out  high-water mark of count     (META_QUEUE_STATS_EN)
// Build option: define META_QUEUE_STATS_EN to add the statistics outputs.
module meta_queue
  import meta_queue_pkg::*;
#(
  parameter int DATA_BITS = 64,
  parameter int DEPTH     = 8
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  metaIntf.s                     s_meta,
  metaIntf.m                     m_meta,
  output logic [$clog2(DEPTH):0] count
`ifdef META_QUEUE_STATS_EN
  ,
  output logic [31:0]            stat_pushes,
  output logic [$clog2(DEPTH):0] stat_max_count
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_BITS-1:0] mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ready_q, ready_d;

  logic valid;
  logic push;
  logic pop;
  op_e  op;

  assign valid = (count_q != '0);
  // ready_q is the only gate on push, so a full queue never accepts a word
  // even if the consumer pops on the same edge.
  assign push  = s_meta.valid && ready_q;
  assign pop   = valid && m_meta.ready;
  assign op    = decode_op(push, pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers are exactly log2(DEPTH) bits, so +1 wraps modulo DEPTH.
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case (op)
      OP_PUSH: count_d = count_q + CW'(1);
      OP_POP:  count_d = count_q - CW'(1);
      OP_BOTH: count_d = count_q;
      OP_NONE: count_d = count_q;
    endcase
    // Registered ready: computed from next occupancy so it tracks count
    // without any path from m_meta.ready to s_meta.ready in the same cycle.
    ready_d = (count_d != FULL_CNT);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
    end
  end

  // Storage carries no reset; its contents are don't-care while empty.
  always_ff @(posedge aclk) begin
    if (push) mem_q[wr_ptr_q] <= s_meta.data;
  end

  assign s_meta.ready = ready_q;
  assign m_meta.valid = valid;
  assign m_meta.data  = mem_q[rd_ptr_q];
  assign count        = count_q;

`ifdef META_QUEUE_STATS_EN
  logic [31:0]   stat_pushes_q;
  logic [CW-1:0] stat_max_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stat_pushes_q <= '0;
      stat_max_q    <= '0;
    end else begin
      if (push) stat_pushes_q <= stat_pushes_q + 32'd1;
      if (count_d > stat_max_q) stat_max_q <= count_d;
    end
  end

  assign stat_pushes    = stat_pushes_q;
  assign stat_max_count = stat_max_q;
`endif

endmodule

// File: tb/tb_meta_queue.sv
// tb/tb_meta_queue.sv - directed and scoreboarded bench for meta_queue
module tb_meta_queue;

  localparam int DATA_BITS = 64;
  localparam int DEPTH     = 8;

  logic       aclk;
  logic       aresetn;
  logic [3:0] count;
`ifdef META_QUEUE_STATS_EN
  logic [31:0] stat_pushes;
  logic [3:0]  stat_max_count;
`endif

  metaIntf #(.DATA_BITS(DATA_BITS)) s_if ();
  metaIntf #(.DATA_BITS(DATA_BITS)) m_if ();

  meta_queue #(.DATA_BITS(DATA_BITS), .DEPTH(DEPTH)) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .s_meta         (s_if),
    .m_meta         (m_if),
    .count          (count)
`ifdef META_QUEUE_STATS_EN
    ,
    .stat_pushes    (stat_pushes),
    .stat_max_count (stat_max_count)
`endif
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int errors = 0;
  int checks = 0;
  logic [63:0] sbq[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic push_n(input logic [63:0] base, input int n);
    m_if.ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      s_if.valid = 1'b1;
      s_if.data  = base + 64'(i);
      step();
    end
    s_if.valid = 1'b0;
  endtask

  task automatic drain_n(input string tag, input logic [63:0] base, input int n);
    s_if.valid = 1'b0;
    m_if.ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      check(tag, m_if.data, base + 64'(i));
      step();
    end
    m_if.ready = 1'b0;
  endtask

  initial begin
    aresetn    = 1'b0;
    s_if.valid = 1'b0;
    s_if.data  = '0;
    m_if.ready = 1'b0;

    // Reset state
    step();
    step();
    check("rst_valid", 64'(m_if.valid), 64'd0);
    check("rst_ready", 64'(s_if.ready), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    aresetn = 1'b1;
    #1;
    check("ready_before_first_edge", 64'(s_if.ready), 64'd0);
    step();
    check("ready_after_first_edge", 64'(s_if.ready), 64'd1);
`ifdef META_QUEUE_STATS_EN
    check("stat_pushes_rst", 64'(stat_pushes), 64'd0);
    check("stat_max_rst", 64'(stat_max_count), 64'd0);
`endif

    // Single transfer
    s_if.valid = 1'b1;
    s_if.data  = 64'hA5;
    #1;
    check("single_no_passthru", 64'(m_if.valid), 64'd0);
    step();
    s_if.valid = 1'b0;
    check("single_valid", 64'(m_if.valid), 64'd1);
    check("single_data", m_if.data, 64'hA5);
    check("single_count", 64'(count), 64'd1);
    m_if.ready = 1'b1;
    step();
    m_if.ready = 1'b0;
    check("single_pop_count", 64'(count), 64'd0);
    check("single_pop_valid", 64'(m_if.valid), 64'd0);

    // Fill to full with ten offered words; only 0..7 may be accepted
    m_if.ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      s_if.valid = 1'b1;
      s_if.data  = 64'(i);
      step();
      check("fill_hold_data", m_if.data, 64'd0);
      if (i == 6) check("fill_ready_at7", 64'(s_if.ready), 64'd1);
      if (i == 7) check("fill_ready_at8", 64'(s_if.ready), 64'd0);
    end
    s_if.valid = 1'b0;
    check("fill_count", 64'(count), 64'd8);
    check("fill_ready", 64'(s_if.ready), 64'd0);
    drain_n("fill_drain", 64'd0, 8);
    check("fill_empty_count", 64'(count), 64'd0);
    check("fill_empty_valid", 64'(m_if.valid), 64'd0);

    // Full with concurrent pop: the offered word must be refused
    push_n(64'h100, 8);
    check("fullpop_pre_count", 64'(count), 64'd8);
    s_if.valid = 1'b1;
    s_if.data  = 64'hDEAD;
    m_if.ready = 1'b1;
    step();
    s_if.valid = 1'b0;
    m_if.ready = 1'b0;
    check("fullpop_count", 64'(count), 64'd7);
    check("fullpop_ready", 64'(s_if.ready), 64'd1);
    drain_n("fullpop_drain", 64'h101, 7);
    check("fullpop_empty", 64'(count), 64'd0);

    // Simultaneous push/pop at count=3 for 20 cycles (pointers wrap)
    push_n(64'h200, 3);
    for (int k = 0; k < 20; k++) begin
      s_if.valid = 1'b1;
      s_if.data  = 64'h203 + 64'(k);
      m_if.ready = 1'b1;
      check("both_data", m_if.data, 64'h200 + 64'(k));
      step();
      check("both_count", 64'(count), 64'd3);
    end
    s_if.valid = 1'b0;
    drain_n("both_drain", 64'h214, 3);
    check("both_empty", 64'(count), 64'd0);

    // Random backpressure with scoreboard and stability checks
    begin
      int sent = 0;
      int got = 0;
      int cyc = 0;
      logic stall = 1'b0;
      logic [63:0] held = '0;
      logic do_push, do_pop;
      sbq.delete();
      while ((sent < 1000 || got < sent) && cyc < 20000) begin
        if (stall) begin
          check("stable_valid", 64'(m_if.valid), 64'd1);
          check("stable_data", m_if.data, held);
        end
        s_if.valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
        s_if.data  = {$urandom, $urandom};
        m_if.ready = ($urandom_range(0, 2) != 0);
        do_push = s_if.valid && s_if.ready;
        do_pop  = m_if.valid && m_if.ready;
        if (do_pop) begin
          if (sbq.size() == 0) begin
            check("rand_spurious_valid", 64'd1, 64'd0);
          end else begin
            check("rand_data", m_if.data, sbq[0]);
            void'(sbq.pop_front());
          end
          got++;
        end
        if (do_push) begin
          sbq.push_back(s_if.data);
          sent++;
        end
        stall = m_if.valid && !m_if.ready;
        held  = m_if.data;
        step();
        cyc++;
        check("rand_count", 64'(count), 64'(sbq.size()));
      end
      if (cyc >= 20000) check("rand_timeout", 64'd0, 64'd1);
      s_if.valid = 1'b0;
      m_if.ready = 1'b0;
    end

    // Reset mid-stream at count=5
    push_n(64'h300, 5);
    check("midrst_pre_count", 64'(count), 64'd5);
    aresetn = 1'b0;
    #1;
    check("midrst_valid", 64'(m_if.valid), 64'd0);
    check("midrst_count", 64'(count), 64'd0);
    check("midrst_ready", 64'(s_if.ready), 64'd0);
    step();
    step();
    aresetn = 1'b1;
    step();
    check("midrst_ready_after", 64'(s_if.ready), 64'd1);
    s_if.valid = 1'b1;
    s_if.data  = 64'h11;
    step();
    s_if.valid = 1'b0;
    check("midrst_first_data", m_if.data, 64'h11);
    check("midrst_first_valid", 64'(m_if.valid), 64'd1);
    check("midrst_first_count", 64'(count), 64'd1);
`ifdef META_QUEUE_STATS_EN
    check("midrst_stat_pushes", 64'(stat_pushes), 64'd1);
    check("midrst_stat_max", 64'(stat_max_count), 64'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
